// File: rtl/dcmac_0_axis_pkt_mon_pkg.sv
// Shared constants, per-ID framing states and the LBUS segment bundle for the packet monitor.
// The segment bundle is ID-independent; the checker prepends an ID_W-wide id field to form lbus_pkt_t.
package dcmac_0_axis_pkt_mon_pkg;

   localparam int SEG_NUM   = 12;
   localparam int SEG_BYTES = 16;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      IDLE  = 2'd1,
      INPKT = 2'd2
   } id_state_e;

   typedef struct packed {
      logic [SEG_NUM-1:0]        ena;
      logic [SEG_NUM-1:0]        sop;
      logic [SEG_NUM-1:0]        eop;
      logic [SEG_NUM-1:0]        err;
      logic [SEG_NUM-1:0][3:0]   mty;
      logic [SEG_NUM-1:0][127:0] dat;
   } lbus_body_t;

   localparam int LBUS_BODY_W = $bits(lbus_body_t);

   // mty only trims the final segment of a packet.
   function automatic logic [4:0] seg_bytes(input logic eop, input logic [3:0] mty);
      return eop ? (5'd16 - {1'b0, mty}) : 5'd16;
   endfunction

endpackage

// File: rtl/dcmac_0_axis_pkt_mon_seg_cnt_chk.sv
// One segment: valid byte count and counter-pattern mismatch against a start offset.
// Purely combinational; no flow control.
module dcmac_0_axis_pkt_mon_seg_cnt_chk
   import dcmac_0_axis_pkt_mon_pkg::*;
(
   input  logic [7:0]   i_start_off,
   input  logic [3:0]   i_mty,
   input  logic         i_eop,
   input  logic [127:0] i_dat,
   output logic [4:0]   o_byte_cnt,
   output logic         o_mis
);

   logic [SEG_BYTES-1:0] byte_bad;

   assign o_byte_cnt = seg_bytes(i_eop, i_mty);

   // Byte 0 sits in the top lane; bytes beyond the valid count are don't-care.
   always_comb begin
      byte_bad = '0;
      for (int j = 0; j < SEG_BYTES; j++) begin
         byte_bad[j] = (j < int'(o_byte_cnt)) &&
                       (i_dat[127-8*j -: 8] != (i_start_off + 8'(j)));
      end
   end

   assign o_mis = |byte_bad;

endmodule

// File: rtl/dcmac_0_axis_pkt_mon_seg_check.sv
// Per-ID framing tracker and statistics counters for the compacted 12-segment LBUS word.
// Two-cycle latency to the counters; always accepts input, no backpressure.
module dcmac_0_axis_pkt_mon_seg_check
   import dcmac_0_axis_pkt_mon_pkg::*;
#(
   parameter  int COUNTER_MODE = 1,
   parameter  int NUM_ID       = 6,
   parameter  int CNT_W        = 48,
   localparam int ID_W         = (NUM_ID == 1) ? 1 : $clog2(NUM_ID)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ID_W+LBUS_BODY_W-1:0] i_pkt,
   input  logic                        i_clr,
   output logic [CNT_W-1:0]            o_pkt_cnt,
   output logic [CNT_W-1:0]            o_byte_cnt,
   output logic [31:0]                 o_err_pkt_cnt,
   output logic [31:0]                 o_frm_err_cnt,
   output logic [31:0]                 o_dat_err_cnt,
   output logic                        o_frm_err,
   output logic                        o_dat_err
);

   typedef struct packed {
      logic [ID_W-1:0] id;
      lbus_body_t      body;
   } lbus_pkt_t;

   lbus_pkt_t       pkt;
   logic            id_ok;
   logic [ID_W-1:0] id_idx;

   assign pkt    = i_pkt;
   assign id_ok  = int'(pkt.id) < NUM_ID;
   assign id_idx = id_ok ? pkt.id : '0;

   // Per-ID framing state
   id_state_e  st_q  [NUM_ID];
   id_state_e  st_d  [NUM_ID];
   logic [7:0] off_q [NUM_ID];
   logic [7:0] off_d [NUM_ID];
   logic       bad_q [NUM_ID];
   logic       bad_d [NUM_ID];

   // Offset chain only needs byte counts, so it is independent of the framing decision.
   logic [7:0] seg_off [SEG_NUM];
   logic [7:0] off_run;
   logic [7:0] off_end;

   always_comb begin
      off_run = off_q[id_idx];
      for (int k = 0; k < SEG_NUM; k++) begin
         seg_off[k] = pkt.body.sop[k] ? 8'd0 : off_run;
         if (pkt.body.ena[k]) begin
            off_run = seg_off[k] + 8'(seg_bytes(pkt.body.eop[k], pkt.body.mty[k]));
         end
      end
      off_end = off_run;
   end

   logic [4:0]         seg_cnt [SEG_NUM];
   logic [SEG_NUM-1:0] seg_mis;

   for (genvar g = 0; g < SEG_NUM; g++) begin : g_seg
      dcmac_0_axis_pkt_mon_seg_cnt_chk u_chk (
         .i_start_off (seg_off[g]),
         .i_mty       (pkt.body.mty[g]),
         .i_eop       (pkt.body.eop[g]),
         .i_dat       (pkt.body.dat[g]),
         .o_byte_cnt  (seg_cnt[g]),
         .o_mis       (seg_mis[g])
      );
   end

   // Stage 1 per-segment events
   logic [SEG_NUM-1:0] done_d, done_q;
   logic [SEG_NUM-1:0] errp_d, errp_q;
   logic [SEG_NUM-1:0] date_d, date_q;
   logic [SEG_NUM-1:0] frm_d,  frm_q;
   logic [SEG_NUM-1:0] mis_d,  mis_q;
   logic [4:0]         bytes_d [SEG_NUM];
   logic [4:0]         bytes_q [SEG_NUM];

   id_state_e cur_st;
   logic      cur_bad;
   logic      acc;
   logic      mis_k;

   always_comb begin
      st_d    = st_q;
      off_d   = off_q;
      bad_d   = bad_q;
      done_d  = '0;
      errp_d  = '0;
      date_d  = '0;
      frm_d   = '0;
      mis_d   = '0;
      for (int k = 0; k < SEG_NUM; k++) bytes_d[k] = '0;
      cur_st  = st_q[id_idx];
      cur_bad = bad_q[id_idx];
      acc     = 1'b0;
      mis_k   = 1'b0;
      if (id_ok) begin
         for (int k = 0; k < SEG_NUM; k++) begin
            acc   = 1'b0;
            mis_k = (COUNTER_MODE != 0) && seg_mis[k];
            if (pkt.body.ena[k]) begin
               if (pkt.body.sop[k]) begin
                  frm_d[k] = (cur_st == INPKT);
                  acc      = 1'b1;
                  cur_bad  = mis_k;
                  cur_st   = INPKT;
               end else if (cur_st == IDLE) begin
                  frm_d[k] = 1'b1;
               end else if (cur_st == INPKT) begin
                  acc      = 1'b1;
                  cur_bad  = cur_bad | mis_k;
               end
               if (acc) begin
                  bytes_d[k] = seg_cnt[k];
                  mis_d[k]   = mis_k;
                  if (pkt.body.eop[k]) begin
                     done_d[k] = 1'b1;
                     errp_d[k] = pkt.body.err[k];
                     date_d[k] = cur_bad;
                     cur_st    = IDLE;
                  end
               end
            end
         end
         st_d[id_idx]  = cur_st;
         off_d[id_idx] = off_end;
         bad_d[id_idx] = cur_bad;
      end
      // A clear also kills the events of the word presented alongside it.
      if (i_clr) begin
         done_d = '0;
         errp_d = '0;
         date_d = '0;
         frm_d  = '0;
         mis_d  = '0;
         for (int k = 0; k < SEG_NUM; k++) bytes_d[k] = '0;
      end
   end

   // Stage 2 accumulation
   logic [3:0] pkt_sum, errp_sum, date_sum, frm_sum;
   logic [7:0] byte_sum;

   always_comb begin
      pkt_sum  = '0;
      errp_sum = '0;
      date_sum = '0;
      frm_sum  = '0;
      byte_sum = '0;
      for (int k = 0; k < SEG_NUM; k++) begin
         pkt_sum  = pkt_sum  + 4'(done_q[k]);
         errp_sum = errp_sum + 4'(errp_q[k]);
         date_sum = date_sum + 4'(date_q[k]);
         frm_sum  = frm_sum  + 4'(frm_q[k]);
         byte_sum = byte_sum + 8'(bytes_q[k]);
      end
   end

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c, input logic [7:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, c} + (CNT_W+1)'(inc);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   function automatic logic [31:0] sat_err(input logic [31:0] c, input logic [3:0] inc);
      logic [32:0] s;
      s = {1'b0, c} + 33'(inc);
      return s[32] ? '1 : s[31:0];
   endfunction

   logic [CNT_W-1:0] pkt_cnt_d,  pkt_cnt_q;
   logic [CNT_W-1:0] byte_cnt_d, byte_cnt_q;
   logic [31:0]      errp_cnt_d, errp_cnt_q;
   logic [31:0]      frm_cnt_d,  frm_cnt_q;
   logic [31:0]      date_cnt_d, date_cnt_q;
   logic             frm_err_d,  frm_err_q;
   logic             dat_err_d,  dat_err_q;

   always_comb begin
      pkt_cnt_d  = sat_cnt(pkt_cnt_q,  8'(pkt_sum));
      byte_cnt_d = sat_cnt(byte_cnt_q, byte_sum);
      errp_cnt_d = sat_err(errp_cnt_q, errp_sum);
      frm_cnt_d  = sat_err(frm_cnt_q,  frm_sum);
      date_cnt_d = sat_err(date_cnt_q, date_sum);
      frm_err_d  = frm_err_q | (|frm_q);
      dat_err_d  = dat_err_q | (|mis_q);
      if (i_clr) begin
         pkt_cnt_d  = '0;
         byte_cnt_d = '0;
         errp_cnt_d = '0;
         frm_cnt_d  = '0;
         date_cnt_d = '0;
         frm_err_d  = 1'b0;
         dat_err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ID; i++) begin
            st_q[i]  <= HUNT;
            off_q[i] <= '0;
            bad_q[i] <= 1'b0;
         end
         done_q     <= '0;
         errp_q     <= '0;
         date_q     <= '0;
         frm_q      <= '0;
         mis_q      <= '0;
         for (int k = 0; k < SEG_NUM; k++) bytes_q[k] <= '0;
         pkt_cnt_q  <= '0;
         byte_cnt_q <= '0;
         errp_cnt_q <= '0;
         frm_cnt_q  <= '0;
         date_cnt_q <= '0;
         frm_err_q  <= 1'b0;
         dat_err_q  <= 1'b0;
      end else begin
         st_q       <= st_d;
         off_q      <= off_d;
         bad_q      <= bad_d;
         done_q     <= done_d;
         errp_q     <= errp_d;
         date_q     <= date_d;
         frm_q      <= frm_d;
         mis_q      <= mis_d;
         bytes_q    <= bytes_d;
         pkt_cnt_q  <= pkt_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         errp_cnt_q <= errp_cnt_d;
         frm_cnt_q  <= frm_cnt_d;
         date_cnt_q <= date_cnt_d;
         frm_err_q  <= frm_err_d;
         dat_err_q  <= dat_err_d;
      end
   end

   assign o_pkt_cnt     = pkt_cnt_q;
   assign o_byte_cnt    = byte_cnt_q;
   assign o_err_pkt_cnt = errp_cnt_q;
   assign o_frm_err_cnt = frm_cnt_q;
   assign o_dat_err_cnt = date_cnt_q;
   assign o_frm_err     = frm_err_q;
   assign o_dat_err     = dat_err_q;

endmodule

// File: tb/tb_dcmac_0_axis_pkt_mon_seg_check.sv
// Directed bench for the segment checker: a vector table of single-cycle words plus
// hand-written multi-cycle sequences (back-to-back, IDLE error, reset, saturation, clear).
module tb_dcmac_0_axis_pkt_mon_seg_check;
   import dcmac_0_axis_pkt_mon_pkg::*;

   localparam int ID_W = 3;

   typedef struct packed {
      logic [ID_W-1:0] id;
      lbus_body_t      body;
   } tb_pkt_t;

   typedef struct {
      int          id;
      logic [11:0] ena, sop, eop, err;
      logic [3:0]  mty;
      int          cseg, cbyte;
      int          e_pkt, e_byte, e_errp, e_frm, e_dat, e_fs, e_ds;
   } vec_t;

   logic    clk = 1'b0;
   logic    rst;
   logic    i_clr;
   tb_pkt_t pkt;

   logic [47:0] d_pkt, d_byte;
   logic [31:0] d_errp, d_frm, d_dat;
   logic        d_fs, d_ds;
   logic [47:0] p_pkt, p_byte;
   logic [31:0] p_errp, p_frm, p_dat;
   logic        p_fs, p_ds;
   logic [7:0]  s_pkt, s_byte;
   logic [31:0] s_errp, s_frm, s_dat;
   logic        s_fs, s_ds;

   int tests = 0;
   int fails = 0;
   vec_t vecs [9];

   always #5 clk = ~clk;

   dcmac_0_axis_pkt_mon_seg_check #(.COUNTER_MODE(1), .NUM_ID(6), .CNT_W(48)) u_dut (
      .clk(clk), .rst(rst), .i_pkt(pkt), .i_clr(i_clr),
      .o_pkt_cnt(d_pkt), .o_byte_cnt(d_byte), .o_err_pkt_cnt(d_errp),
      .o_frm_err_cnt(d_frm), .o_dat_err_cnt(d_dat), .o_frm_err(d_fs), .o_dat_err(d_ds));

   dcmac_0_axis_pkt_mon_seg_check #(.COUNTER_MODE(0), .NUM_ID(6), .CNT_W(48)) u_prbs (
      .clk(clk), .rst(rst), .i_pkt(pkt), .i_clr(i_clr),
      .o_pkt_cnt(p_pkt), .o_byte_cnt(p_byte), .o_err_pkt_cnt(p_errp),
      .o_frm_err_cnt(p_frm), .o_dat_err_cnt(p_dat), .o_frm_err(p_fs), .o_dat_err(p_ds));

   dcmac_0_axis_pkt_mon_seg_check #(.COUNTER_MODE(1), .NUM_ID(6), .CNT_W(8)) u_sat (
      .clk(clk), .rst(rst), .i_pkt(pkt), .i_clr(i_clr),
      .o_pkt_cnt(s_pkt), .o_byte_cnt(s_byte), .o_err_pkt_cnt(s_errp),
      .o_frm_err_cnt(s_frm), .o_dat_err_cnt(s_dat), .o_frm_err(s_fs), .o_dat_err(s_ds));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_dut(input string tag, input int ep, input int eb, input int eerr,
                          input int efrm, input int edat, input int efs, input int eds);
      chk({tag, " pkt_cnt"},     64'(d_pkt),  64'(ep));
      chk({tag, " byte_cnt"},    64'(d_byte), 64'(eb));
      chk({tag, " err_pkt_cnt"}, 64'(d_errp), 64'(eerr));
      chk({tag, " frm_err_cnt"}, 64'(d_frm),  64'(efrm));
      chk({tag, " dat_err_cnt"}, 64'(d_dat),  64'(edat));
      chk({tag, " frm_err"},     64'(d_fs),   64'(efs));
      chk({tag, " dat_err"},     64'(d_ds),   64'(eds));
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      i_clr = 1'b0;
      pkt   = '0;
      tick();
      tick();
      rst   = 1'b0;
   endtask

   // Adds one enabled segment with counter bytes start, start+1, ...
   task automatic seg(input int k, input bit s, input bit e, input logic [3:0] m, input int start);
      pkt.body.ena[k] = 1'b1;
      pkt.body.sop[k] = s;
      pkt.body.eop[k] = e;
      pkt.body.mty[k] = m;
      for (int j = 0; j < 16; j++) pkt.body.dat[k][127-8*j -: 8] = 8'(start + j);
   endtask

   task automatic build(input vec_t v);
      int off;
      pkt = '0;
      pkt.id = ID_W'(v.id);
      off = 0;
      for (int k = 0; k < 12; k++) begin
         if (v.ena[k]) begin
            if (v.sop[k]) off = 0;
            seg(k, v.sop[k], v.eop[k], v.mty, off);
            pkt.body.err[k] = v.err[k];
            off = off + (v.eop[k] ? 16 - int'(v.mty) : 16);
         end
      end
      if (v.cseg >= 0) pkt.body.dat[v.cseg][127-8*v.cbyte -: 8] = 8'hFF;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //          id ena     sop     eop     err     mty   cseg cb pkt byte errp frm dat fs ds
      vecs[0] = '{2, 12'h00F, 12'h001, 12'h008, 12'h000, 4'd0, -1, 0, 1,  64, 0, 0, 0, 0, 0};
      vecs[1] = '{0, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 4'd6, -1, 0, 12, 120, 0, 0, 0, 0, 0};
      vecs[2] = '{1, 12'h003, 12'h001, 12'h002, 12'h002, 4'd4, -1, 0, 1,  28, 1, 0, 0, 0, 0};
      vecs[3] = '{3, 12'h005, 12'h001, 12'h004, 12'h000, 4'd0, -1, 0, 1,  32, 0, 0, 0, 0, 0};
      vecs[4] = '{4, 12'h003, 12'h000, 12'h002, 12'h000, 4'd0, -1, 0, 0,   0, 0, 0, 0, 0, 0};
      vecs[5] = '{5, 12'h007, 12'h003, 12'h004, 12'h000, 4'd0, -1, 0, 1,  48, 0, 1, 0, 1, 0};
      vecs[6] = '{2, 12'h007, 12'h001, 12'h004, 12'h000, 4'd0,  1, 4, 1,  48, 0, 0, 1, 0, 1};
      vecs[7] = '{0, 12'hFFF, 12'h001, 12'h800, 12'h001, 4'd5, -1, 0, 1, 187, 0, 0, 0, 0, 0};
      vecs[8] = '{1, 12'h001, 12'h001, 12'h001, 12'h000, 4'd15,-1, 0, 1,   1, 0, 0, 0, 0, 0};

      do_reset();
      chk_dut("reset", 0, 0, 0, 0, 0, 0, 0);
      chk("reset sat pkt_cnt", 64'(s_pkt), 64'd0);

      for (int i = 0; i < 9; i++) begin
         do_reset();
         build(vecs[i]);
         tick();
         pkt = '0;
         tick();
         chk_dut($sformatf("vec%0d", i), vecs[i].e_pkt, vecs[i].e_byte, vecs[i].e_errp,
                 vecs[i].e_frm, vecs[i].e_dat, vecs[i].e_fs, vecs[i].e_ds);
         chk($sformatf("vec%0d prbs pkt_cnt", i), 64'(p_pkt), 64'(vecs[i].e_pkt));
         chk($sformatf("vec%0d prbs dat_err_cnt", i), 64'(p_dat), 64'd0);
      end

      // Same ID on consecutive cycles: second word must see the first word's state.
      do_reset();
      pkt.id = 3'd2; seg(0, 1, 0, 0, 0); seg(1, 0, 0, 0, 16);
      tick();
      pkt = '0; pkt.id = 3'd2; seg(0, 0, 0, 0, 32); seg(1, 0, 1, 0, 48);
      tick();
      pkt = '0;
      tick();
      chk_dut("b2b", 1, 64, 0, 0, 0, 0, 0);

      // IDLE ID: non-sop segment is a framing error, then sop/eop in seg1 counts.
      do_reset();
      pkt.id = 3'd3; seg(0, 1, 1, 0, 0);
      tick(); pkt = '0; tick();
      chk_dut("idle_setup", 1, 16, 0, 0, 0, 0, 0);
      pkt.id = 3'd3; seg(0, 0, 0, 0, 0); seg(1, 1, 1, 0, 0);
      tick(); pkt = '0; tick();
      chk_dut("idle_nonsop", 2, 32, 0, 1, 0, 1, 0);

      // Reset mid-packet, then continuation without sop is silently dropped.
      do_reset();
      pkt.id = 3'd2; seg(0, 1, 0, 0, 0);
      tick();
      pkt = '0; rst = 1'b1;
      tick();
      rst = 1'b0;
      pkt.id = 3'd2; seg(0, 0, 0, 0, 16); seg(1, 0, 1, 0, 32);
      tick(); pkt = '0; tick(); tick();
      chk_dut("rst_mid", 0, 0, 0, 0, 0, 0, 0);
      pkt.id = 3'd2; seg(0, 1, 1, 0, 0);
      tick(); pkt = '0; tick();
      chk_dut("rst_next", 1, 16, 0, 0, 0, 0, 0);

      // 25 cycles x 12 packets of 16B = 300 packets, 4800 bytes.
      do_reset();
      for (int c = 0; c < 25; c++) begin
         pkt = '0; pkt.id = 3'd1;
         for (int k = 0; k < 12; k++) seg(k, 1, 1, 0, 0);
         tick();
      end
      pkt = '0;
      tick(); tick();
      chk("sat pkt_cnt", 64'(s_pkt), 64'd255);
      chk("sat byte_cnt", 64'(s_byte), 64'd255);
      chk("wide pkt_cnt", 64'(d_pkt), 64'd300);
      chk("wide byte_cnt", 64'(d_byte), 64'd4800);
      pkt.id = 3'd1; seg(0, 1, 1, 0, 0);
      tick(); pkt = '0; tick(); tick();
      chk("sat hold pkt_cnt", 64'(s_pkt), 64'd255);
      chk("sat hold byte_cnt", 64'(s_byte), 64'd255);

      // Clear coincident with an eop zeroes everything; framing state survives.
      do_reset();
      pkt.id = 3'd0; seg(0, 1, 1, 0, 0);
      tick();
      pkt = '0; pkt.id = 3'd0; seg(0, 0, 0, 0, 0);
      tick(); pkt = '0; tick();
      chk_dut("clr_setup", 1, 16, 0, 1, 0, 1, 0);
      pkt.id = 3'd0; seg(0, 1, 1, 0, 0); i_clr = 1'b1;
      tick();
      pkt = '0; i_clr = 1'b0;
      chk_dut("clr", 0, 0, 0, 0, 0, 0, 0);
      pkt.id = 3'd0; seg(0, 0, 0, 0, 0);
      tick(); pkt = '0; tick(); tick();
      chk("clr keeps state frm_err_cnt", 64'(d_frm), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
